// File: rtl/param_sync_sram.sv
// param_sync_sram
// Parametrised single-port synchronous SRAM with a registered read port,
// byte-enable writes, a selectable same-address read-during-write policy,
// a read-valid strobe and an optional post-reset zero-fill sequencer.
//
// Parameters:
//   DATA_WIDTH     word width in bits (multiple of 8)
//   ADDR_WIDTH     address width; DEPTH = 2**ADDR_WIDTH words
//   RDW_MODE       0 = read-first (old word), 1 = write-first (merged word)
//   CLEAR_ON_RESET 1 = zero-fill the array after reset, 0 = no clear
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (never resets the array itself)
//   write_en   write request
//   read_en    read request
//   address    shared read/write address
//   data_in    write data
//   byte_en    per-byte write mask, bit i covers data_in[8i+7:8i]
//   data_out   registered read data, holds between reads
//   read_valid data_out was loaded by a read on the previous edge
//   init_busy  clear sequence running; requests are ignored
module param_sync_sram #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    write_en,
  input  logic                    read_en,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    read_valid,
  output logic                    init_busy
);

  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  state_t                  state_q;
  state_t                  state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q;
  logic [ADDR_WIDTH-1:0]   clr_cnt_d;

  logic [DATA_WIDTH-1:0]   ram [DEPTH];

  logic [DATA_WIDTH-1:0]   old_word;
  logic [DATA_WIDTH-1:0]   merged_word;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    rd_load;

  // Word as it will look after a byte-masked write of data_in.
  always_comb begin
    old_word    = ram[address];
    merged_word = old_word;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if (byte_en[i]) begin
        merged_word[8*i +: 8] = data_in[8*i +: 8];
      end
    end
  end

  // merged_word equals old_word when byte_en is zero, so a masked-off
  // write-first access still returns the unchanged word.
  always_comb begin
    rd_word = old_word;
    if ((RDW_MODE != 0) && write_en) begin
      rd_word = merged_word;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_addr  = address;
    mem_wdata = merged_word;
    rd_load   = 1'b0;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_cnt_q;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) begin
          state_d = READY;
        end
      end
      READY: begin
        mem_we  = write_en && (|byte_en);
        rd_load = read_en;
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_STATE;
      clr_cnt_q  <= '0;
      data_out   <= '0;
      read_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      read_valid <= rd_load;
      if (rd_load) begin
        data_out <= rd_word;
      end
    end
  end

  // Array has no reset; writes are blocked while rst_n is low so contents
  // survive a reset when no clear is configured.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) begin
      ram[mem_addr] <= mem_wdata;
    end
  end

  assign init_busy = (state_q == CLEAR);

endmodule
